// File: rtl/hood_pkg.sv
// Shared range-hood definitions: gear one-hot codes, timer FSM states, default clock rate.
package hood_pkg;

  localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;

  localparam logic [2:0] GEAR1 = 3'b001;
  localparam logic [2:0] GEAR2 = 3'b010;
  localparam logic [2:0] GEAR3 = 3'b100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REMIND = 2'd2,
    SNOOZE = 2'd3
  } hood_state_t;

endpackage

// File: rtl/sec_prescaler.sv
// One-second prescaler: counts enabled cycles 0..CLK_HZ-1 and emits a registered tick on wrap.
module sec_prescaler
  import hood_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc,
  output logic sec_tick
);

  localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt;

  // tc is the combinational terminal count so the owner can update in step with sec_tick.
  assign tc = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt      <= '0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= tc;
      if (tc)
        cnt <= '0;
      else if (en)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/range_hood_clean_timer.sv
// Weighted fan-usage timer raising the cleaning reminder for the sound stage.
// Optional snooze support is built when CLEAN_SNOOZE_EN is defined.
module range_hood_clean_timer
  import hood_pkg::*;
#(
  parameter int unsigned CLK_HZ        = CLK_HZ_DEFAULT,
  parameter int unsigned THRESHOLD_SEC = 36000,
  parameter int unsigned USAGE_W       = 20,
  parameter int unsigned SNOOZE_SEC    = 600
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               power_on,
  input  logic [2:0]         suction,
  input  logic               clean_done,
`ifdef CLEAN_SNOOZE_EN
  input  logic               snooze,
`endif
  output logic               cleaning_reminder,
  output logic [USAGE_W-1:0] usage_sec,
  output logic               sec_tick
);

  hood_state_t        state;
  logic               running;
  logic               tc;
  logic               pre_en;
  logic               pre_clr;
  logic [USAGE_W:0]   usage_sum;
  logic [USAGE_W-1:0] usage_next;
  logic               hit;

  assign running = power_on &&
                   ((suction == GEAR1) || (suction == GEAR2) || (suction == GEAR3));

  always_comb begin
    usage_sum  = {1'b0, usage_sec} + ((suction == GEAR3) ? (USAGE_W+1)'(2) : (USAGE_W+1)'(1));
    usage_next = usage_sec;
    if (tc && running)
      usage_next = usage_sum[USAGE_W] ? '1 : usage_sum[USAGE_W-1:0];
    hit = 32'(usage_next) >= THRESHOLD_SEC;
  end

`ifdef CLEAN_SNOOZE_EN
  localparam int unsigned SNZ_W = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC + 1) : 1;
  logic [SNZ_W-1:0] snz_cnt;
  logic             snooze_go;

  // Snooze restarts the prescaler so the snooze period is a whole number of seconds.
  assign snooze_go = (state == REMIND) && snooze && !clean_done;
  assign pre_en    = running || ((state == SNOOZE) && power_on);
  assign pre_clr   = clean_done || snooze_go;
`else
  assign pre_en    = running;
  assign pre_clr   = clean_done;
`endif

  sec_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clr      (pre_clr),
    .en       (pre_en),
    .tc       (tc),
    .sec_tick (sec_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      usage_sec         <= '0;
      cleaning_reminder <= 1'b0;
`ifdef CLEAN_SNOOZE_EN
      snz_cnt           <= '0;
`endif
    end else begin
      cleaning_reminder <= (state == REMIND) && power_on;
      if (clean_done) begin
        usage_sec <= '0;
        state     <= running ? RUN : IDLE;
      end else begin
        usage_sec <= usage_next;
        case (state)
          IDLE:   if (running) state <= hit ? REMIND : RUN;
          RUN:    if (hit) state <= REMIND;
                  else if (!running) state <= IDLE;
          REMIND: begin
`ifdef CLEAN_SNOOZE_EN
            if (snooze) begin
              state   <= SNOOZE;
              snz_cnt <= SNZ_W'(SNOOZE_SEC);
            end
`endif
          end
`ifdef CLEAN_SNOOZE_EN
          SNOOZE: if (tc) begin
            if (snz_cnt <= SNZ_W'(1))
              state <= REMIND;
            else
              snz_cnt <= snz_cnt - 1'b1;
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_range_hood_clean_timer.sv
// Self-checking bench for range_hood_clean_timer with CLK_HZ=10, THRESHOLD_SEC=5.
module tb_range_hood_clean_timer;

  localparam int unsigned USAGE_W = 20;

  logic               clk = 1'b0;
  logic               rst;
  logic               power_on;
  logic [2:0]         suction;
  logic               clean_done;
  logic               snooze;
  logic               cleaning_reminder;
  logic [USAGE_W-1:0] usage_sec;
  logic               sec_tick;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  range_hood_clean_timer #(
    .CLK_HZ        (10),
    .THRESHOLD_SEC (5),
    .USAGE_W       (USAGE_W),
    .SNOOZE_SEC    (2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .power_on          (power_on),
    .suction           (suction),
    .clean_done        (clean_done),
`ifdef CLEAN_SNOOZE_EN
    .snooze            (snooze),
`endif
    .cleaning_reminder (cleaning_reminder),
    .usage_sec         (usage_sec),
    .sec_tick          (sec_tick)
  );

  typedef struct {
    string       name;
    int unsigned sel;   // 0 usage_sec, 1 cleaning_reminder, 2 sec_tick
    int unsigned exp;
  } exp_t;

  typedef struct {
    logic        power;
    logic [2:0]  gear;
    int unsigned cycles;
    int unsigned exp_usage;
    logic        exp_rem;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string name, input int unsigned sel, input int unsigned e);
    exp_t x;
    x.name = name;
    x.sel  = sel;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    int unsigned act;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      case (x.sel)
        0:       act = int'(usage_sec);
        1:       act = int'(cleaning_reminder);
        default: act = int'(sec_tick);
      endcase
      vectors++;
      if (act != x.exp) begin
        miscompares++;
        $display("FAIL %s: got %0d, expected %0d", x.name, act, x.exp);
      end
    end
  endtask

  task automatic do_clean();
    clean_done = 1'b1;
    step(1);
    clean_done = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 3'b001, 10,  1, 1'b0};
    vecs[1] = '{1'b1, 3'b010, 20,  2, 1'b0};
    vecs[2] = '{1'b1, 3'b100, 20,  4, 1'b0};
    vecs[3] = '{1'b1, 3'b100, 31,  6, 1'b1};
    vecs[4] = '{1'b1, 3'b011, 100, 0, 1'b0};
    vecs[5] = '{1'b1, 3'b000, 100, 0, 1'b0};
    vecs[6] = '{1'b0, 3'b001, 100, 0, 1'b0};
    vecs[7] = '{1'b1, 3'b101, 100, 0, 1'b0};
    vecs[8] = '{1'b1, 3'b001, 50,  5, 1'b0};
    vecs[9] = '{1'b1, 3'b001, 51,  5, 1'b1};

    rst = 1'b1; power_on = 1'b0; suction = 3'b000; clean_done = 1'b0; snooze = 1'b0;
    step(2);
    expect_val("reset_usage", 0, 0);
    expect_val("reset_rem",   1, 0);
    expect_val("reset_tick",  2, 0);
    drain();

    // First tick CLK_HZ cycles after running begins, reminder one cycle after threshold
    rst = 1'b0; power_on = 1'b1; suction = 3'b001;
    step(9);
    expect_val("tick_c9", 2, 0);
    drain();
    step(1);
    expect_val("tick_c10", 2, 1);
    expect_val("usage_c10", 0, 1);
    drain();
    step(1);
    expect_val("tick_c11", 2, 0);
    drain();
    step(39);
    expect_val("usage_c50", 0, 5);
    expect_val("rem_c50", 1, 0);
    drain();
    step(1);
    expect_val("rem_c51", 1, 1);
    drain();

    // Power drop silences reminder; restore (no gear) brings it back
    power_on = 1'b0;
    step(1);
    expect_val("rem_pwr_off", 1, 0);
    drain();
    step(30);
    expect_val("usage_pwr_off", 0, 5);
    expect_val("rem_pwr_off_hold", 1, 0);
    drain();
    suction = 3'b000; power_on = 1'b1;
    step(1);
    expect_val("rem_pwr_back", 1, 1);
    expect_val("usage_pwr_back", 0, 5);
    drain();

    // clean_done from REMIND
    clean_done = 1'b1;
    step(1);
    clean_done = 1'b0;
    expect_val("clean_usage_n1", 0, 0);
    drain();
    step(1);
    expect_val("clean_rem_n2", 1, 0);
    drain();

    // clean_done coincident with the terminal count at usage 3
    suction = 3'b001;
    do_clean();
    step(30);
    expect_val("pre_coinc_usage", 0, 3);
    drain();
    step(9);
    expect_val("pre_coinc_usage9", 0, 3);
    expect_val("pre_coinc_tick9", 2, 0);
    drain();
    clean_done = 1'b1;
    step(1);
    clean_done = 1'b0;
    expect_val("coinc_usage", 0, 0);
    expect_val("coinc_tick", 2, 0);
    expect_val("coinc_rem", 1, 0);
    drain();
    step(10);
    expect_val("coinc_restart", 0, 1);
    drain();

    for (int i = 0; i < 10; i++) begin
      power_on = vecs[i].power;
      suction  = vecs[i].gear;
      do_clean();
      step(vecs[i].cycles);
      expect_val($sformatf("vec%0d_usage", i), 0, vecs[i].exp_usage);
      expect_val($sformatf("vec%0d_rem", i),   1, int'(vecs[i].exp_rem));
      drain();
    end

`ifdef CLEAN_SNOOZE_EN
    power_on = 1'b1; suction = 3'b001;
    do_clean();
    step(51);
    expect_val("snz_pre_rem", 1, 1);
    drain();
    snooze = 1'b1;
    step(1);
    snooze = 1'b0;
    step(1);
    expect_val("snz_rem_s1", 1, 0);
    drain();
    step(19);
    expect_val("snz_rem_s20", 1, 0);
    drain();
    step(1);
    expect_val("snz_rem_s21", 1, 1);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/range_hood_clean_timer.md
# range_hood_clean_timer

Upstream feeder for the range hood's audio stage: accumulates the hood's fan running time while a suction gear is engaged, then raises the `cleaning_reminder` level that the sound stage uses to switch from gear tones to the 440 Hz reminder tone. Third gear counts as double wear. The user clears the timer with a one-cycle `clean_done` pulse from the button debouncer. Runs entirely in the 100 MHz `clk` domain.

## Interface
- `CLK_HZ`, 100_000_000: clock cycles per second of usage.
- `THRESHOLD_SEC`, 36000: weighted usage seconds at which the reminder fires.
- `USAGE_W`, 20: width of the usage accumulator.
- `SNOOZE_SEC`, 600: snooze duration; used only with `CLEAN_SNOOZE_EN`.

- `clk`  in  1: system clock, 100 MHz.
- `rst`  in  1: synchronous, active-high reset.
- `power_on`  in  1: hood master power level.
- `suction`  in  3: gear, one-hot. 001 = gear 1, 010 = gear 2, 100 = gear 3, anything else = no valid gear.
- `clean_done`  in  1: single-cycle pulse; the user has cleaned the hood.
- `snooze`  in  1: single-cycle pulse; only present with `CLEAN_SNOOZE_EN`.
- `cleaning_reminder`  out  1: reminder level to the sound stage.
- `usage_sec`  out  USAGE_W: weighted usage seconds, for display.
- `sec_tick`  out  1: one-cycle pulse on each counted second.

## Operation
- Running: `power_on`=1 and `suction` is a valid one-hot value.
- Prescaler:
  - Counts 0..CLK_HZ-1 only while running; it holds its value otherwise.
  - Terminal count produces `sec_tick` and the prescaler wraps to 0.
- Accumulation on `sec_tick`:
  - `usage_sec` += 2 when `suction`=100, += 1 otherwise.
  - Saturates at 2^USAGE_W-1 and never wraps.
- FSM states and transitions:
  - IDLE -> RUN when running.
  - RUN -> IDLE when not running.
  - RUN -> REMIND when the updated `usage_sec` >= THRESHOLD_SEC.
  - REMIND persists across power-off and gear changes. Accumulation continues while running.
- `cleaning_reminder`: registered, equal to (state==REMIND) && `power_on` from the previous cycle. It is silenced while power is off, and reasserts when power returns.
- `clean_done`, from any state:
  - Clears `usage_sec` and the prescaler to 0.
  - Next state is RUN if running, else IDLE.
  - `clean_done` has priority over a simultaneous `sec_tick`; that tick is discarded.
- Invalid `suction` values (000, multi-hot) are treated as not running. No error flag is raised.

## Timing
- Reset values: `cleaning_reminder`=0, `usage_sec`=0, `sec_tick`=0, prescaler 0, state IDLE.
- `rst` mid-count discards all accumulated usage.
- `sec_tick` is registered. It is high for the single cycle after the prescaler reaches CLK_HZ-1, so the first tick comes CLK_HZ cycles after running begins.
- `usage_sec` updates in the same cycle `sec_tick` is high.
- State becomes REMIND on the cycle `usage_sec` first meets the threshold. `cleaning_reminder` rises one cycle later.
- `clean_done` at cycle N: `usage_sec`=0 and state left REMIND at N+1, `cleaning_reminder`=0 at N+2.
- When the weight-2 increment jumps over THRESHOLD_SEC, the >= compare still fires.

## Configuration
- `CLEAN_SNOOZE_EN` defined:
  - A `snooze` pulse in REMIND moves the FSM to SNOOZE, which loads a SNOOZE_SEC down-counter.
  - The counter decrements on the prescaler terminal count regardless of gear, but only while `power_on`.
  - `cleaning_reminder`=0 in SNOOZE. On expiry the FSM returns to REMIND.
  - `clean_done` overrides SNOOZE with the normal clear.
  - `snooze` outside REMIND is ignored.
- `CLEAN_SNOOZE_EN` undefined: no `snooze` port, no SNOOZE state or counter, and behaviour is exactly as above.

## Structure
- Shared package `hood_pkg`:
  - Gear one-hot constants `GEAR1`/`GEAR2`/`GEAR3` = 3'b001/3'b010/3'b100, shared with the sound stage.
  - FSM state enum (IDLE, RUN, REMIND, SNOOZE).
  - Default CLK_HZ.
- One natural sub-module, `sec_prescaler`: enable in, `sec_tick` out, synchronous clear. It is reused by the snooze counter.

## Test plan
Bench uses CLK_HZ=10 and THRESHOLD_SEC=5.
- Reset, then power_on=1, suction=001 -> first `sec_tick` at cycle 10; `usage_sec`=5 at cycle 50; `cleaning_reminder` rises at cycle 51.
- suction=100 -> `usage_sec` steps 2, 4, 6. REMIND fires when it reaches 6, proving the >= overshoot case.
- In REMIND, drop power_on -> `cleaning_reminder`=0 a cycle later. Restore power -> `cleaning_reminder`=1 again with `usage_sec` unchanged.
- `clean_done` coincident with `sec_tick` at `usage_sec`=3 -> `usage_sec`=0 (tick discarded), reminder stays 0.
- suction=011 or 000 with power_on=1 -> no ticks for 100 cycles and `usage_sec` holds.
- With `CLEAN_SNOOZE_EN`, SNOOZE_SEC=2: `snooze` in REMIND -> reminder 0 for 20 cycles, then 1.
